// File: rtl/cla_group_serial_adder.sv
// cla_group_serial_adder: serial adder/subtractor that resolves one 4-bit
// carry-lookahead group per clock, least significant group first.
//
// Optional feature macro: CLA_OVERFLOW_FLAG_EN (adds the ovf output).
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   start    in   begin an operation (accepted in IDLE or DONE only)
//   op_sub   in   0 = a+b+ci, 1 = a-b
//   a, b     in   WIDTH-bit operands, sampled with start
//   ci       in   carry-in for add, ignored for subtract
//   busy     out  high while groups are being processed
//   done     out  one-cycle pulse when s/co are final
//   s        out  WIDTH-bit result
//   co       out  carry-out (subtract: 1 = no borrow)
//   ovf      out  signed overflow (only with CLA_OVERFLOW_FLAG_EN)
module cla_group_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef CLA_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned G  = WIDTH / 4;
  localparam int unsigned KW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef CLA_OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  // Current group slice and its lookahead carries
  logic [3:0] grp_a, grp_b, grp_g, grp_p, grp_sum;
  logic [4:0] c;
  logic       last_grp;

  always_comb begin
    grp_a = 4'(a_q >> {k_q, 2'b00});
    grp_b = 4'(b_q >> {k_q, 2'b00});
    grp_g = grp_a & grp_b;
    grp_p = grp_a | grp_b;
    c[0]  = carry_q;
    c[1]  = grp_g[0] | (grp_p[0] & c[0]);
    c[2]  = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c[0]);
    c[3]  = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[2] & grp_p[1] & grp_p[0] & c[0]);
    c[4]  = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c[0]);
    grp_sum  = grp_a ^ grp_b ^ c[3:0];
    last_grp = (k_q == KW'(G - 1));
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef CLA_OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : ci;
          k_d     = '0;
          s_d     = '0;
          co_d    = 1'b0;
`ifdef CLA_OVERFLOW_FLAG_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Unprocessed groups of s are still zero, so OR-in is sufficient
        s_d     = s_q | (WIDTH'(grp_sum) << {k_q, 2'b00});
        carry_d = c[4];
        if (last_grp) begin
          co_d    = c[4];
`ifdef CLA_OVERFLOW_FLAG_EN
          ovf_d   = c[3] ^ c[4];
`endif
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CLA_OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CLA_OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
`ifdef CLA_OVERFLOW_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_group_serial_adder.sv
// Testbench for cla_group_serial_adder: three instances (WIDTH 8/16/32)
// share operand inputs but have private start/reset; a scoreboard queue
// holds expected results, popped when an instance pulses done.
module tb_cla_group_serial_adder;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  start_v;
  logic        op_sub;
  logic        ci;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  co_v;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
`ifdef CLA_OVERFLOW_FLAG_EN
  logic [2:0]  ovf_v;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          inst;
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  cla_group_serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(rst_n[0]), .start(start_v[0]), .op_sub(op_sub),
    .a(a[7:0]), .b(b[7:0]), .ci(ci), .busy(busy_v[0]), .done(done_v[0]),
    .s(s8), .co(co_v[0])
`ifdef CLA_OVERFLOW_FLAG_EN
    , .ovf(ovf_v[0])
`endif
  );

  cla_group_serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .reset_n(rst_n[1]), .start(start_v[1]), .op_sub(op_sub),
    .a(a[15:0]), .b(b[15:0]), .ci(ci), .busy(busy_v[1]), .done(done_v[1]),
    .s(s16), .co(co_v[1])
`ifdef CLA_OVERFLOW_FLAG_EN
    , .ovf(ovf_v[1])
`endif
  );

  cla_group_serial_adder #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(rst_n[2]), .start(start_v[2]), .op_sub(op_sub),
    .a(a), .b(b), .ci(ci), .busy(busy_v[2]), .done(done_v[2]),
    .s(s32), .co(co_v[2])
`ifdef CLA_OVERFLOW_FLAG_EN
    , .ovf(ovf_v[2])
`endif
  );

  function automatic int width_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 16 : 32;
  endfunction

  function automatic int groups_of(input int i);
    return width_of(i) / 4;
  endfunction

  function automatic logic [31:0] get_s(input int i);
    case (i)
      0:       return 32'(s8);
      1:       return 32'(s16);
      default: return s32;
    endcase
  endfunction

  // Reference: plain wide addition; overflow from operand/result signs
  function automatic exp_t model(input int i, input logic op, input logic [31:0] av,
                                 input logic [31:0] bv, input logic civ);
    exp_t        r;
    int          w;
    logic [32:0] mask, aa, bb, sum;
    w    = width_of(i);
    mask = (33'd1 << w) - 33'd1;
    aa   = {1'b0, av} & mask;
    bb   = (op ? ~{1'b0, bv} : {1'b0, bv}) & mask;
    sum  = aa + bb + 33'(op ? 1'b1 : civ);
    r.inst = i;
    r.s    = 32'(sum & mask);
    r.co   = sum[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic scramble();
    a      = $urandom;
    b      = $urandom;
    ci     = 1'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic launch(input int i, input logic op, input logic [31:0] av,
                        input logic [31:0] bv, input logic civ, input bit push);
    a          = av;
    b          = bv;
    ci         = civ;
    op_sub     = op;
    start_v[i] = 1'b1;
    if (push) sbq.push_back(model(i, op, av, bv, civ));
  endtask

  // Called at cycle 0 (just after a rising edge); returns at the next cycle 0
  task automatic run_op(input int i, input logic op, input logic [31:0] av,
                        input logic [31:0] bv, input logic civ);
    exp_t e;
    int   g;
    e = model(i, op, av, bv, civ);
    g = groups_of(i);
    launch(i, op, av, bv, civ, 1'b1);
    at_neg();
    chk($sformatf("w%0d_busy_c0", width_of(i)), 32'(busy_v[i]), 32'd0);
    tick();
    start_v[i] = 1'b0;
    scramble();
    for (int cy = 1; cy <= g; cy++) begin
      at_neg();
      chk($sformatf("w%0d_busy_c%0d", width_of(i), cy), 32'(busy_v[i]), 32'd1);
      chk($sformatf("w%0d_done_c%0d", width_of(i), cy), 32'(done_v[i]), 32'd0);
      if (cy == 1) begin
        chk($sformatf("w%0d_s_cleared", width_of(i)), get_s(i), 32'd0);
        chk($sformatf("w%0d_co_cleared", width_of(i)), 32'(co_v[i]), 32'd0);
      end
      tick();
    end
    at_neg();
    chk($sformatf("w%0d_done_pulse", width_of(i)), 32'(done_v[i]), 32'd1);
    chk($sformatf("w%0d_busy_done", width_of(i)), 32'(busy_v[i]), 32'd0);
    tick();
    at_neg();
    chk($sformatf("w%0d_done_drop", width_of(i)), 32'(done_v[i]), 32'd0);
    chk($sformatf("w%0d_s_hold", width_of(i)), get_s(i), e.s);
    chk($sformatf("w%0d_co_hold", width_of(i)), 32'(co_v[i]), 32'(e.co));
    tick();
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        if (sbq.size() == 0) begin
          chk($sformatf("w%0d_spurious_done", width_of(i)), 32'(i), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_inst", 32'(i), 32'(e.inst));
          chk($sformatf("w%0d_sb_s", width_of(i)), get_s(i), e.s);
          chk($sformatf("w%0d_sb_co", width_of(i)), 32'(co_v[i]), 32'(e.co));
`ifdef CLA_OVERFLOW_FLAG_EN
          chk($sformatf("w%0d_sb_ovf", width_of(i)), 32'(ovf_v[i]), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    rst_n   = 3'b000;
    start_v = 3'b111;
    a       = 32'hFFFF_FFFF;
    b       = 32'hFFFF_FFFF;
    ci      = 1'b1;
    op_sub  = 1'b0;
    tick();
    tick();
    start_v = 3'b000;

    // Reset state (start asserted alongside reset must not have been taken)
    at_neg();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w%0d_rst_busy", width_of(i)), 32'(busy_v[i]), 32'd0);
      chk($sformatf("w%0d_rst_done", width_of(i)), 32'(done_v[i]), 32'd0);
      chk($sformatf("w%0d_rst_s", width_of(i)), get_s(i), 32'd0);
      chk($sformatf("w%0d_rst_co", width_of(i)), 32'(co_v[i]), 32'd0);
`ifdef CLA_OVERFLOW_FLAG_EN
      chk($sformatf("w%0d_rst_ovf", width_of(i)), 32'(ovf_v[i]), 32'd0);
`endif
    end
    tick();
    rst_n = 3'b111;
    tick();

    // 8-bit carry ripple through both groups, then subtract and overflow
    run_op(0, 1'b0, 32'hFF, 32'h01, 1'b0);
    run_op(0, 1'b1, 32'h05, 32'h07, 1'b0);
    run_op(0, 1'b0, 32'h7F, 32'h01, 1'b0);

    // 32-bit with a start during RUN that must be ignored
    launch(2, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
    tick();
    start_v[2] = 1'b0;
    for (int cy = 1; cy <= 8; cy++) begin
      if (cy == 4) begin
        start_v[2] = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h1111_1111;
        op_sub = 1'b1;
      end else begin
        start_v[2] = 1'b0;
      end
      at_neg();
      chk($sformatf("w32_ign_busy_c%0d", cy), 32'(busy_v[2]), 32'd1);
      tick();
    end
    at_neg();
    chk("w32_ign_done_c9", 32'(done_v[2]), 32'd1);
    tick();
    at_neg();
    chk("w32_ign_busy_c10", 32'(busy_v[2]), 32'd0);
    chk("w32_ign_s_hold", s32, 32'h2222_2222);
    tick();

    // 8-bit back-to-back: start held high through DONE
    launch(0, 1'b0, 32'hA5, 32'h5A, 1'b1, 1'b1);
    tick();
    a = 32'h3C;
    b = 32'h81;
    op_sub = 1'b1;
    ci = 1'b0;
    sbq.push_back(model(0, 1'b1, 32'h3C, 32'h81, 1'b0));
    for (int cy = 1; cy <= 6; cy++) begin
      if (cy == 4) begin
        start_v[0] = 1'b0;
        scramble();
      end
      at_neg();
      chk($sformatf("w8_b2b_busy_c%0d", cy), 32'(busy_v[0]),
          (cy == 3 || cy == 6) ? 32'd0 : 32'd1);
      chk($sformatf("w8_b2b_done_c%0d", cy), 32'(done_v[0]),
          (cy == 3 || cy == 6) ? 32'd1 : 32'd0);
      tick();
    end

    // 16-bit reset during RUN: abort, no done, start under reset ignored
    launch(1, 1'b0, 32'h1234, 32'h4321, 1'b0, 1'b0);
    tick();
    start_v[1] = 1'b0;
    at_neg();
    chk("w16_abort_busy_c1", 32'(busy_v[1]), 32'd1);
    tick();
    rst_n[1]   = 1'b0;
    start_v[1] = 1'b1;
    at_neg();
    chk("w16_abort_busy_c2", 32'(busy_v[1]), 32'd1);
    tick();
    rst_n[1]   = 1'b1;
    start_v[1] = 1'b0;
    at_neg();
    chk("w16_abort_busy", 32'(busy_v[1]), 32'd0);
    chk("w16_abort_done", 32'(done_v[1]), 32'd0);
    chk("w16_abort_s", 32'(s16), 32'd0);
    chk("w16_abort_co", 32'(co_v[1]), 32'd0);
`ifdef CLA_OVERFLOW_FLAG_EN
    chk("w16_abort_ovf", 32'(ovf_v[1]), 32'd0);
`endif
    for (int cy = 4; cy <= 6; cy++) begin
      tick();
      at_neg();
      chk($sformatf("w16_abort_idle_c%0d", cy), 32'(busy_v[1]), 32'd0);
      chk($sformatf("w16_abort_nodone_c%0d", cy), 32'(done_v[1]), 32'd0);
    end
    tick();
    run_op(1, 1'b0, 32'hFFFF, 32'h0001, 1'b0);
    run_op(1, 1'b1, 32'h8000, 32'h0001, 1'b0);

    // Boundaries and a few random operations
    run_op(0, 1'b1, 32'h00, 32'h00, 1'b0);
    run_op(2, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run_op(2, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_op(n % 3, 1'($urandom), $urandom, $urandom, 1'($urandom));
    end

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_group_serial_adder.md
CLA_GROUP_SERIAL_ADDER -- requirements
Module: cla_group_serial_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant G = WIDTH/4, the number of 4-bit lookahead groups; no separate parameter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to begin an operation; sampled on the rising edge.
REQ-006 op_sub  input  1  0 = a+b+ci, 1 = a-b (two's complement); sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 ci  input  1  carry-in for add; ignored when op_sub=1; sampled with start.
REQ-010 busy  output  1  high while groups are being processed.
REQ-011 done  output  1  one-cycle pulse when s and co are final.
REQ-012 s  output  WIDTH  registered sum/difference.
REQ-013 co  output  1  registered carry-out (for subtract: 1 = no borrow).
REQ-014 ovf  output  1  registered signed-overflow flag; present only with the Configuration macro.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 start accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-017 On acceptance: latch A=a, B=(op_sub ? ~b : b), carry=(op_sub ? 1 : ci); group counter k=0; s cleared to 0; co cleared; next state RUN.
REQ-018 Each RUN cycle processes group k with 4-bit carry lookahead, g[i]=A&B, p[i]=A|B, carries c1..c3 and group carry-out from g/p/carry. Sum bits = A^B^carry-in-of-bit. Results write s[4k+3:4k], carry updated to group carry-out, k increments.
REQ-019 After group G-1: co = final carry, next state DONE.
REQ-020 Latency: start high in cycle 0 (accepted) gives busy high in cycles 1..G, and done high in cycle G+1 only.
REQ-021 DONE lasts one cycle, then IDLE unless start is accepted in DONE. An accepted start in DONE goes straight to RUN, giving back-to-back operations with no idle cycle.
REQ-022 s, co (and ovf) SHALL hold their final values from DONE until the next accepted start.
REQ-023 Bits of s for groups not yet processed SHALL read 0 during RUN.
REQ-024 k wraps only by returning to 0 on acceptance; it is never read beyond G-1.
REQ-025 Changes to a, b, ci and op_sub after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force IDLE, k=0, busy=0, done=0, s=0, co=0, ovf=0, and clear latched operands and carry, regardless of state.
REQ-027 Reset during RUN aborts the operation; no done pulse follows.
REQ-028 start sampled in the same cycle as reset_n=0 SHALL be ignored.

Configuration
REQ-029 Macro CLA_OVERFLOW_FLAG_EN defined: port ovf exists. It is set in the cycle entering DONE to (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), and cleared on acceptance.
REQ-030 Macro undefined: no ovf port and no overflow logic; all other behaviour identical.

Verification
REQ-031 WIDTH=8, add a=0xFF, b=0x01, ci=0, start in cycle 0 -> busy in cycles 1-2, done in cycle 3, s=0x00, co=1.
REQ-032 WIDTH=8, op_sub=1, a=0x05, b=0x07 -> s=0xFE, co=0; with macro, ovf=0. Then a=0x7F, b=0x01 add -> s=0x80, co=0, ovf=1.
REQ-033 WIDTH=32, a=0x12345678, b=0x0FEDCBA9, ci=1 -> done in cycle 9, s=0x22222222, co=0. A second start in cycle 4 with other operands is ignored.
REQ-034 WIDTH=8, start held high through DONE -> second operation accepted in cycle 3, busy in cycles 4-5, done in cycle 6; results of the first operation are correct in cycle 3.
REQ-035 WIDTH=16, reset_n=0 in cycle 2 of RUN -> next cycle IDLE with all outputs 0, no done pulse. A subsequent operation then completes correctly.
